// File: rtl/sw_max_score_tracker.sv
// rtl/sw_max_score_tracker.sv - best-cell score tracker on the Smith-Waterman score bus
//
// Purpose:
//   Scans every accepted score cycle of a query. For each query it keeps the
//   highest lane score, the lane that produced it, and the cycle offset at
//   which it first appeared. When the query ends, the result goes into a
//   2-entry first-word-fall-through FIFO for the host result writer.
//
// Ports:
//   clk, rst           engine clock; synchronous active-high reset
//   stall              freezes input capture, both pipeline stages and the cycle counter
//   V_in               NUM_PES lanes of WIDTH-bit unsigned scores
//   v_valid_in         V_in carries valid scores this cycle
//   query_id_in        query tag, used on the last cycle of the query
//   query_last_in      final score cycle of the query (qualified by v_valid_in)
//   res_*_out          head FIFO record: score, lane, cycle offset, query tag
//   res_valid_out      FIFO not empty
//   res_rdy_in         consumer takes the head record
//   fifo_full_out      both FIFO entries occupied
//   overflow_out       sticky: a record was dropped because the FIFO was full
module sw_max_score_tracker #(
    parameter int NUM_PES  = 64,
    parameter int WIDTH    = 10,
    parameter int PE_IDX_W = 6,
    parameter int QID_W    = 8,
    parameter int CYC_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [NUM_PES*WIDTH-1:0]   V_in,
    input  logic                       v_valid_in,
    input  logic [QID_W-1:0]           query_id_in,
    input  logic                       query_last_in,
    output logic [WIDTH-1:0]           res_score_out,
    output logic [PE_IDX_W-1:0]        res_pe_out,
    output logic [CYC_W-1:0]           res_cycle_out,
    output logic [QID_W-1:0]           res_qid_out,
    output logic                       res_valid_out,
    input  logic                       res_rdy_in,
    output logic                       fifo_full_out,
    output logic                       overflow_out
);

    localparam int REC_W = WIDTH + PE_IDX_W + CYC_W + QID_W;

    // ------------------------------------------------------------------
    // Lane max-reduce. Strict '>' while scanning upward keeps the lowest
    // lane index on ties.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    cyc_max;
    logic [PE_IDX_W-1:0] cyc_pe;

    always_comb begin
        cyc_max = V_in[WIDTH-1:0];
        cyc_pe  = '0;
        for (int i = 1; i < NUM_PES; i++) begin
            if (V_in[i*WIDTH +: WIDTH] > cyc_max) begin
                cyc_max = V_in[i*WIDTH +: WIDTH];
                cyc_pe  = PE_IDX_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 and the cycle-offset counter.
    // The counter holds the offset the next accepted cycle will carry.
    // ------------------------------------------------------------------
    logic [CYC_W-1:0]    cyc_cnt;
    logic                s1_valid;
    logic                s1_last;
    logic [WIDTH-1:0]    s1_max;
    logic [PE_IDX_W-1:0] s1_pe;
    logic [CYC_W-1:0]    s1_cyc;
    logic [QID_W-1:0]    s1_qid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_max   <= '0;
            s1_pe    <= '0;
            s1_cyc   <= '0;
            s1_qid   <= '0;
        end else if (!stall) begin
            s1_valid <= v_valid_in;
            if (v_valid_in) begin
                s1_max  <= cyc_max;
                s1_pe   <= cyc_pe;
                s1_cyc  <= cyc_cnt;
                s1_last <= query_last_in;
                s1_qid  <= query_id_in;
                if (query_last_in) begin
                    cyc_cnt <= '0;
                end else if (cyc_cnt != {CYC_W{1'b1}}) begin
                    cyc_cnt <= cyc_cnt + CYC_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: running max. Strict '>' keeps the earliest cycle on ties.
    // The "final" value folds in the current stage-1 cycle so a last cycle
    // that carries the best score is still reported.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]    run_max;
    logic [PE_IDX_W-1:0] run_pe;
    logic [CYC_W-1:0]    run_cyc;

    logic                upd;
    logic [WIDTH-1:0]    fin_max;
    logic [PE_IDX_W-1:0] fin_pe;
    logic [CYC_W-1:0]    fin_cyc;

    always_comb begin
        upd     = (s1_max > run_max);
        fin_max = upd ? s1_max : run_max;
        fin_pe  = upd ? s1_pe  : run_pe;
        fin_cyc = upd ? s1_cyc : run_cyc;
    end

    // Push register: a one-cycle pulse consumed by the FIFO on the next
    // edge whatever the stall level, so a stalled pipeline never writes a
    // record twice.
    logic             push_valid;
    logic [REC_W-1:0] push_rec;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max    <= '0;
            run_pe     <= '0;
            run_cyc    <= '0;
            push_valid <= 1'b0;
            push_rec   <= '0;
        end else begin
            push_valid <= ~stall & s1_valid & s1_last;
            if (!stall && s1_valid) begin
                if (s1_last) begin
                    push_rec <= {fin_max, fin_pe, fin_cyc, s1_qid};
                    // Clear on the same edge so a query that follows
                    // immediately starts from zero.
                    run_max  <= '0;
                    run_pe   <= '0;
                    run_cyc  <= '0;
                end else begin
                    run_max  <= fin_max;
                    run_pe   <= fin_pe;
                    run_cyc  <= fin_cyc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry first-word-fall-through result FIFO.
    // ------------------------------------------------------------------
    logic [REC_W-1:0] mem [0:1];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             full;
    logic             pop;
    logic             push_ok;

    always_comb begin
        full    = (count == 2'd2);
        pop     = (count != 2'd0) & res_rdy_in;
        // A pop on the same edge frees a slot, so a push while full still lands.
        push_ok = push_valid & (~full | pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]       <= '0;
            mem[1]       <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
            overflow_out <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push_valid && !push_ok) begin
                overflow_out <= 1'b1;
            end
        end
    end

    assign {res_score_out, res_pe_out, res_cycle_out, res_qid_out} = mem[rd_ptr];
    assign res_valid_out = (count != 2'd0);
    assign fifo_full_out = full;

endmodule

// File: tb/tb_sw_max_score_tracker.sv
// tb/tb_sw_max_score_tracker.sv - scoreboard bench for sw_max_score_tracker
module tb_sw_max_score_tracker;

    localparam int NP = 64;
    localparam int W  = 10;
    localparam int PW = 6;
    localparam int QW = 8;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [NP*W-1:0]   V_in;
    logic              v_valid_in;
    logic [QW-1:0]     query_id_in;
    logic              query_last_in;
    logic [W-1:0]      res_score_out;
    logic [PW-1:0]     res_pe_out;
    logic [CW-1:0]     res_cycle_out;
    logic [QW-1:0]     res_qid_out;
    logic              res_valid_out;
    logic              res_rdy_in;
    logic              fifo_full_out;
    logic              overflow_out;

    sw_max_score_tracker #(
        .NUM_PES(NP), .WIDTH(W), .PE_IDX_W(PW), .QID_W(QW), .CYC_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .V_in(V_in),
        .v_valid_in(v_valid_in), .query_id_in(query_id_in),
        .query_last_in(query_last_in), .res_score_out(res_score_out),
        .res_pe_out(res_pe_out), .res_cycle_out(res_cycle_out),
        .res_qid_out(res_qid_out), .res_valid_out(res_valid_out),
        .res_rdy_in(res_rdy_in), .fifo_full_out(fifo_full_out),
        .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  score;
        logic [PW-1:0] pe;
        logic [CW-1:0] cyc;
        logic [QW-1:0] qid;
    } rec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference state: accepted cycles of the open query, records in flight
    // (one per pipeline latency step), expected FIFO contents and overflow.
    logic [NP*W-1:0] cur_q[$];
    rec_t            exp_q[$];
    rec_t            s1_rec, push_rec;
    bit              s1_v = 0, push_v = 0, m_ovf = 0;

    always @(negedge clk) begin
        int   sz;
        bit   pop;
        rec_t r;
        logic [NP*W-1:0] cyc_lanes;
        logic [W-1:0]    v;

        chk("res_valid", {31'd0, res_valid_out}, {31'd0, exp_q.size() > 0});
        if (res_valid_out && exp_q.size() > 0) begin
            chk("res_score", {22'd0, res_score_out}, {22'd0, exp_q[0].score});
            chk("res_pe",    {26'd0, res_pe_out},    {26'd0, exp_q[0].pe});
            chk("res_cycle", {16'd0, res_cycle_out}, {16'd0, exp_q[0].cyc});
            chk("res_qid",   {24'd0, res_qid_out},   {24'd0, exp_q[0].qid});
        end
        chk("fifo_full", {31'd0, fifo_full_out}, {31'd0, exp_q.size() == 2});
        chk("overflow",  {31'd0, overflow_out},  {31'd0, m_ovf});

        if (rst) begin
            cur_q.delete();
            exp_q.delete();
            s1_v = 0; push_v = 0; m_ovf = 0;
        end else begin
            sz  = exp_q.size();
            pop = res_rdy_in && sz > 0;
            if (pop) void'(exp_q.pop_front());
            if (push_v) begin
                if (sz == 2 && !pop) m_ovf = 1;
                else exp_q.push_back(push_rec);
            end
            push_v   = !stall && s1_v;
            push_rec = s1_rec;
            if (!stall) begin
                s1_v = 0;
                if (v_valid_in) begin
                    cur_q.push_back(V_in);
                    if (query_last_in) begin
                        // Best over the whole query: earliest cycle, then lowest lane.
                        r = '0;
                        foreach (cur_q[c]) begin
                            cyc_lanes = cur_q[c];
                            for (int l = 0; l < NP; l++) begin
                                v = cyc_lanes[l*W +: W];
                                if (v > r.score) begin
                                    r.score = v;
                                    r.pe    = PW'(l);
                                    r.cyc   = (c > 65535) ? 16'hFFFF : CW'(c);
                                end
                            end
                        end
                        r.qid  = query_id_in;
                        s1_rec = r;
                        s1_v   = 1;
                        cur_q.delete();
                    end
                end
            end
        end
    end

    function automatic logic [NP*W-1:0] lane(input int idx, input int val);
        logic [NP*W-1:0] x;
        x = '0;
        x[idx*W +: W] = W'(val);
        return x;
    endfunction

    task automatic step(input logic v, input logic last, input logic [QW-1:0] qid,
                        input logic [NP*W-1:0] lanes, input logic st, input logic rdy,
                        input logic r);
        v_valid_in    = v;
        query_last_in = last;
        query_id_in   = qid;
        V_in          = lanes;
        stall         = st;
        res_rdy_in    = rdy;
        rst           = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, '0, 0, rdy, 0);
    endtask

    initial begin
        rst = 1; stall = 0; V_in = '0; v_valid_in = 0;
        query_id_in = '0; query_last_in = 0; res_rdy_in = 0;
        repeat (2) @(posedge clk);
        #1;
        idle(2, 1);

        // Single query of three cycles; tie on cycle 2 loses to cycle 1
        step(1, 0, 8'h00, lane(5, 7), 0, 1, 0);
        step(1, 0, 8'h00, lane(9, 12), 0, 1, 0);
        step(1, 1, 8'h3A, lane(2, 12), 0, 1, 0);
        idle(5, 1);

        // Intra-cycle tie resolves to the lower lane
        step(1, 1, 8'h11, lane(4, 20) | lane(60, 20), 0, 1, 0);
        idle(5, 1);

        // All-zero single-cycle query
        step(1, 1, 8'h12, '0, 0, 1, 0);
        idle(4, 1);

        // Back-to-back queries, no gap
        step(1, 0, 8'h21, lane(10, 15), 0, 1, 0);
        step(1, 1, 8'h21, lane(11, 4), 0, 1, 0);
        step(1, 0, 8'h22, lane(1, 2), 0, 1, 0);
        step(1, 1, 8'h22, lane(63, 3), 0, 1, 0);
        idle(5, 1);

        // Stall mid-query with valid held; stalled data must be ignored
        step(1, 0, 8'h31, lane(3, 5), 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'h31, lane(1, 200), 1, 1, 0);
        step(1, 0, 8'h31, lane(7, 9), 0, 1, 0);
        step(1, 1, 8'h31, lane(8, 30), 0, 1, 0);
        idle(5, 1);

        // Backpressure: third record dropped, then drain
        step(1, 1, 8'h41, lane(0, 1), 0, 0, 0);
        step(1, 1, 8'h42, lane(0, 2), 0, 0, 0);
        step(1, 1, 8'h43, lane(0, 3), 0, 0, 0);
        idle(4, 0);
        idle(4, 1);

        // Same again, but a pop lands on the third push edge
        step(0, 0, 8'h00, '0, 0, 0, 1);
        idle(1, 0);
        step(1, 1, 8'h51, lane(0, 1), 0, 0, 0);
        step(1, 1, 8'h52, lane(0, 2), 0, 0, 0);
        step(1, 1, 8'h53, lane(0, 3), 0, 0, 0);
        idle(1, 0);
        idle(1, 1);
        idle(2, 0);
        idle(4, 1);

        // Reset mid-query discards the partial query
        step(1, 0, 8'h61, lane(20, 500), 0, 1, 0);
        step(1, 0, 8'h61, lane(21, 400), 0, 1, 0);
        step(0, 0, 8'h00, '0, 0, 1, 1);
        step(1, 0, 8'h62, lane(22, 6), 0, 1, 0);
        step(1, 1, 8'h62, lane(23, 8), 0, 1, 0);
        idle(5, 1);

        // Random traffic with stalls and random consumer readiness
        for (int i = 0; i < 600; i++) begin
            logic [NP*W-1:0] lv;
            logic vv, ll;
            for (int l = 0; l < NP; l++)
                lv[l*W +: W] = ($urandom % 8 == 0) ? W'($urandom_range(0, 1023)) : W'($urandom_range(0, 15));
            vv = ($urandom % 4) != 0;
            ll = vv && ($urandom % 5 == 0);
            step(vv, ll, QW'($urandom), lv, ($urandom % 8) == 0, $urandom % 2, 0);
        end
        idle(10, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
